serial_subtractor: RTL and testbench

Bit-serial subtraction unit for the ALU datapath. It accepts two WIDTH-bit operands on a start pulse and streams them LSB-first, one bit per clock, through a single `full_subtractor`. A registered borrow carries between bits, and the difference is assembled in a shift register. On completion it reports the difference, borrow-out, zero and signed-overflow flags with a one-cycle done pulse, trading area for WIDTH+1 cycles of latency against the ripple subtractor.

---
 rtl/serial_subtractor_pkg.sv | 12 +
 rtl/serial_subtractor_full_subtractor.sv | 13 +
 rtl/serial_subtractor.sv | 99 +++++++++
 tb/tb_serial_subtractor.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared ALU definitions: serial-unit FSM state encoding and default datapath width.
package serial_subtractor_pkg;

   localparam int unsigned DefaultWidth = 8;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StDone = 2'd2
   } sub_state_e;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// Single-bit full subtractor cell: d = a - b - bin, with borrow out.
module full_subtractor (
   input  logic a_i,
   input  logic b_i,
   input  logic bin_i,
   output logic d_o,
   output logic bout_o
);

   assign d_o    = a_i ^ b_i ^ bin_i;
   assign bout_o = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: streams operands LSB-first through one full_subtractor,
// reporting difference, borrow, zero and signed overflow after WIDTH run cycles.
module serial_subtractor
   import serial_subtractor_pkg::*;
#(
   parameter int unsigned WIDTH = DefaultWidth
) (
   input  logic             in_clk,
   input  logic             in_rst_n,
   input  logic             in_start,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_borrow,
   output logic             out_busy,
   output logic             out_done,
   output logic [WIDTH-1:0] out_diff,
   output logic             out_borrow,
   output logic             out_zero,
   output logic             out_overflow
);

   localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

   sub_state_e       state_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] diff_q;
   logic [CntW-1:0]  cnt_q;
   logic             brw_q;
   logic             done_q;
   logic             borrow_q;
   logic             ovf_q;

   logic             fs_d;
   logic             fs_bout;

   full_subtractor u_fs (
      .a_i   (a_q[0]),
      .b_i   (b_q[0]),
      .bin_i (brw_q),
      .d_o   (fs_d),
      .bout_o(fs_bout)
   );

   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         state_q  <= StIdle;
         a_q      <= '0;
         b_q      <= '0;
         diff_q   <= '0;
         cnt_q    <= '0;
         brw_q    <= 1'b0;
         done_q   <= 1'b0;
         borrow_q <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               if (in_start) begin
                  a_q     <= in_a;
                  b_q     <= in_b;
                  brw_q   <= in_borrow;
                  cnt_q   <= '0;
                  state_q <= StRun;
               end
            end
            StRun: begin
               a_q    <= a_q >> 1;
               b_q    <= b_q >> 1;
               diff_q <= {fs_d, diff_q[WIDTH-1:1]};
               brw_q  <= fs_bout;
               if (cnt_q == CntLast) begin
                  // Signed overflow: borrow into the MSB differs from borrow out of it.
                  ovf_q    <= brw_q ^ fs_bout;
                  borrow_q <= fs_bout;
                  done_q   <= 1'b1;
                  state_q  <= StDone;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            StDone: begin
               done_q  <= 1'b0;
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign out_busy     = (state_q != StIdle);
   assign out_done     = done_q;
   assign out_diff     = diff_q;
   assign out_borrow   = borrow_q;
   assign out_overflow = ovf_q;
   assign out_zero     = (diff_q == '0);

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8) against an arithmetic reference model.
module tb_serial_subtractor;

   localparam int W = 8;

   logic         in_clk = 1'b0;
   logic         in_rst_n = 1'b0;
   logic         in_start = 1'b0;
   logic [W-1:0] in_a = '0;
   logic [W-1:0] in_b = '0;
   logic         in_borrow = 1'b0;
   logic         out_busy, out_done, out_borrow, out_zero, out_overflow;
   logic [W-1:0] out_diff;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [W-1:0] diff;
      logic         borrow;
      logic         zero;
      logic         ovf;
   } exp_t;

   serial_subtractor #(.WIDTH(W)) dut (
      .in_clk      (in_clk),
      .in_rst_n    (in_rst_n),
      .in_start    (in_start),
      .in_a        (in_a),
      .in_b        (in_b),
      .in_borrow   (in_borrow),
      .out_busy    (out_busy),
      .out_done    (out_done),
      .out_diff    (out_diff),
      .out_borrow  (out_borrow),
      .out_zero    (out_zero),
      .out_overflow(out_overflow)
   );

   always #5 in_clk = ~in_clk;

   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
      exp_t e;
      int r, sa, sb, sr;
      r  = int'(a) - int'(b) - int'(bin);
      sa = (a >= 128) ? int'(a) - 256 : int'(a);
      sb = (b >= 128) ? int'(b) - 256 : int'(b);
      sr = sa - sb - int'(bin);
      e.diff   = W'(r & 255);
      e.borrow = (r < 0);
      e.zero   = ((r & 255) == 0);
      e.ovf    = (sr < -128) || (sr > 127);
      return e;
   endfunction

   // Called at #1 after an edge with the DUT idle; returns in the done cycle (or on timeout).
   task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                         output int lat, output bit seen, output int busy_drops);
      in_a = a; in_b = b; in_borrow = bin; in_start = 1'b1;
      @(posedge in_clk); #1;
      in_start = 1'b0;
      lat = 0; busy_drops = 0;
      while (!out_done && lat < 40) begin
         if (!out_busy) busy_drops++;
         @(posedge in_clk); #1;
         lat++;
      end
      seen = out_done;
   endtask

   task automatic test_reset();
      in_rst_n = 1'b0; #1;
      checks++;
      if ({out_busy, out_done, out_diff, out_borrow, out_overflow, out_zero} !== {11'b0, 1'b1}) begin
         failures++;
         $display("FAIL reset_values busy=%b done=%b diff=%h bor=%b ovf=%b zero=%b required 0 0 00 0 0 1",
                  out_busy, out_done, out_diff, out_borrow, out_overflow, out_zero);
      end
      repeat (2) @(posedge in_clk);
      #3 in_rst_n = 1'b1;
      @(posedge in_clk); #1;
      checks++;
      if (out_busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_release_idle busy=%b required 0", out_busy);
      end
   endtask

   task automatic test_directed();
      logic [W-1:0] va [6] = '{8'h35, 8'h00, 8'h80, 8'h05, 8'h10, 8'h7F};
      logic [W-1:0] vb [6] = '{8'h12, 8'h01, 8'h01, 8'h05, 8'h0F, 8'hFF};
      logic         vc [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      int lat, drops; bit seen; exp_t e;
      for (int i = 0; i < 6; i++) begin
         e = model(va[i], vb[i], vc[i]);
         launch(va[i], vb[i], vc[i], lat, seen, drops);
         checks++;
         if (!seen || lat != W || drops != 0) begin
            failures++;
            $display("FAIL dir%0d_timing seen=%b lat=%0d busy_drops=%0d required 1 %0d 0",
                     i, seen, lat, drops, W);
         end
         checks++;
         if ({out_diff, out_borrow, out_zero, out_overflow, out_busy} !==
             {e.diff, e.borrow, e.zero, e.ovf, 1'b1}) begin
            failures++;
            $display("FAIL dir%0d_result diff=%h bor=%b zero=%b ovf=%b busy=%b required %h %b %b %b 1",
                     i, out_diff, out_borrow, out_zero, out_overflow, out_busy,
                     e.diff, e.borrow, e.zero, e.ovf);
         end
         @(posedge in_clk); #1;
         checks++;
         if (out_busy !== 1'b0 || out_done !== 1'b0 || out_diff !== e.diff) begin
            failures++;
            $display("FAIL dir%0d_idle busy=%b done=%b diff=%h required 0 0 %h",
                     i, out_busy, out_done, out_diff, e.diff);
         end
      end
   endtask

   task automatic test_random();
      int lat, drops; bit seen; exp_t e;
      logic [W-1:0] a, b; logic c;
      for (int i = 0; i < 40; i++) begin
         a = W'($urandom); b = W'($urandom); c = 1'($urandom);
         e = model(a, b, c);
         launch(a, b, c, lat, seen, drops);
         checks++;
         if (!seen || lat != W || {out_diff, out_borrow, out_zero, out_overflow} !==
             {e.diff, e.borrow, e.zero, e.ovf}) begin
            failures++;
            $display("FAIL rand%0d a=%h b=%h bin=%b seen=%b lat=%0d got %h %b %b %b required %h %b %b %b",
                     i, a, b, c, seen, lat, out_diff, out_borrow, out_zero, out_overflow,
                     e.diff, e.borrow, e.zero, e.ovf);
         end
         // Next launch happens in the idle cycle right after DONE: back-to-back.
         @(posedge in_clk); #1;
      end
   endtask

   task automatic test_back_to_back();
      int dones = 0, done_cyc = -1, lat, drops; bit seen;
      logic [W-1:0] dgot = '0; logic bgot = 1'b0;
      exp_t e;
      in_a = 8'h35; in_b = 8'h12; in_borrow = 1'b0; in_start = 1'b1;
      @(posedge in_clk); #1;
      for (int cyc = 1; cyc <= 9; cyc++) begin
         in_start = (cyc == 3 || cyc == 9);
         if (in_start) begin in_a = 8'hFF; in_b = 8'h00; end
         if (out_done) begin dones++; done_cyc = cyc; dgot = out_diff; bgot = out_borrow; end
         @(posedge in_clk); #1;
      end
      in_start = 1'b0;
      for (int cyc = 10; cyc <= 11; cyc++) if (out_done) dones++;
      checks++;
      if (dones != 1 || done_cyc != 9 || dgot !== 8'h23 || bgot !== 1'b0) begin
         failures++;
         $display("FAIL b2b_ignored_start dones=%0d done_cyc=%0d diff=%h bor=%b required 1 9 23 0",
                  dones, done_cyc, dgot, bgot);
      end
      checks++;
      if (out_busy !== 1'b0) begin
         failures++;
         $display("FAIL b2b_idle_after_done busy=%b required 0", out_busy);
      end
      e = model(8'hC3, 8'h3C, 1'b1);
      launch(8'hC3, 8'h3C, 1'b1, lat, seen, drops);
      checks++;
      if (!seen || lat != W || out_diff !== e.diff || out_overflow !== e.ovf) begin
         failures++;
         $display("FAIL b2b_next_accepted seen=%b lat=%0d diff=%h ovf=%b required 1 %0d %h %b",
                  seen, lat, out_diff, out_overflow, W, e.diff, e.ovf);
      end
      @(posedge in_clk); #1;
   endtask

   task automatic test_reset_mid_run();
      int dones = 0, lat, drops; bit seen; exp_t e;
      in_a = 8'hA7; in_b = 8'h3C; in_borrow = 1'b1; in_start = 1'b1;
      @(posedge in_clk); #1;
      in_start = 1'b0;
      repeat (3) begin @(posedge in_clk); #1; end
      checks++;
      if (out_busy !== 1'b1) begin
         failures++;
         $display("FAIL rst_mid_busy_before busy=%b required 1", out_busy);
      end
      in_rst_n = 1'b0; #1;
      checks++;
      if ({out_busy, out_done, out_diff, out_borrow, out_overflow, out_zero} !== {11'b0, 1'b1}) begin
         failures++;
         $display("FAIL rst_mid_outputs busy=%b done=%b diff=%h bor=%b ovf=%b zero=%b required 0 0 00 0 0 1",
                  out_busy, out_done, out_diff, out_borrow, out_overflow, out_zero);
      end
      @(posedge in_clk); #3 in_rst_n = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(posedge in_clk); #1;
         if (out_done || out_busy) dones++;
      end
      checks++;
      if (dones != 0) begin
         failures++;
         $display("FAIL rst_mid_no_done activity_cycles=%0d required 0", dones);
      end
      e = model(8'h35, 8'h12, 1'b0);
      launch(8'h35, 8'h12, 1'b0, lat, seen, drops);
      checks++;
      if (!seen || lat != W || out_diff !== e.diff || out_zero !== e.zero) begin
         failures++;
         $display("FAIL rst_mid_recover seen=%b lat=%0d diff=%h zero=%b required 1 %0d %h %b",
                  seen, lat, out_diff, out_zero, W, e.diff, e.zero);
      end
      @(posedge in_clk); #1;
   endtask

   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_reset_mid_run();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
